// File: rtl/fp_widen_adder_pipe.sv
// Three-stage pipelined IEEE-754 adder/subtractor: narrow-format operands in, wide-format sum out,
// rounded to nearest-even. A single global stall (adv) gates every stage register.
// Optional build macro FP_ADD_FLAGS_EN adds out_flags = {invalid, inexact, zero}.
module fp_widen_adder_pipe #(
    parameter int unsigned IN_EXP_W  = 5,
    parameter int unsigned IN_MAN_W  = 10,
    parameter int unsigned OUT_EXP_W = 8,
    parameter int unsigned OUT_MAN_W = 23
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [IN_EXP_W+IN_MAN_W:0]        in_a,
    input  logic [IN_EXP_W+IN_MAN_W:0]        in_b,
    input  logic                              in_sub,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [OUT_EXP_W+OUT_MAN_W:0]      out_data
`ifdef FP_ADD_FLAGS_EN
    ,
    output logic [2:0]                        out_flags
`endif
);

    localparam int unsigned IN_W   = 1 + IN_EXP_W + IN_MAN_W;
    localparam int unsigned OUT_W  = 1 + OUT_EXP_W + OUT_MAN_W;
    localparam int unsigned SIG_W  = IN_MAN_W + 1;
    // Alignment field: full output precision (hidden + fraction) plus guard, round, sticky.
    localparam int unsigned FW     = OUT_MAN_W + 4;
    localparam int unsigned PAD    = FW - SIG_W;
    localparam int unsigned LZW    = $clog2(FW + 1);
    localparam int unsigned BIAS_D = (2 ** (OUT_EXP_W - 1)) - (2 ** (IN_EXP_W - 1));

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- Stage 1: decode, swap, align ----------------
    logic                sa, sb, a_ge_b, s_big;
    logic [IN_EXP_W-1:0] ea, eb, e_big_raw, e_sml_raw, e_big, e_sml, shamt;
    logic [IN_MAN_W-1:0] fa, fb, f_big, f_sml;
    logic [SIG_W-1:0]    sig_big, sig_sml;
    logic [2*FW-1:0]     sml_wide, sml_shift;
    logic [FW-1:0]       big_field, aligned;
    logic                nan_a, nan_b, inf_a, inf_b, inf_clash;

    assign sa = in_a[IN_W-1];
    assign sb = in_b[IN_W-1] ^ in_sub;
    assign ea = in_a[IN_W-2 -: IN_EXP_W];
    assign eb = in_b[IN_W-2 -: IN_EXP_W];
    assign fa = in_a[IN_MAN_W-1:0];
    assign fb = in_b[IN_MAN_W-1:0];

    assign nan_a     = (&ea) && (|fa);
    assign nan_b     = (&eb) && (|fb);
    assign inf_a     = (&ea) && !(|fa);
    assign inf_b     = (&eb) && !(|fb);
    assign inf_clash = inf_a && inf_b && (sa ^ sb);

    // Order by magnitude and shift the smaller significand right, folding lost bits into sticky
    always_comb begin
        a_ge_b    = (in_a[IN_W-2:0] >= in_b[IN_W-2:0]);
        s_big     = a_ge_b ? sa : sb;
        e_big_raw = a_ge_b ? ea : eb;
        e_sml_raw = a_ge_b ? eb : ea;
        f_big     = a_ge_b ? fa : fb;
        f_sml     = a_ge_b ? fb : fa;
        // Subnormals behave as exponent 1 with no hidden bit
        e_big     = (e_big_raw == '0) ? IN_EXP_W'(1) : e_big_raw;
        e_sml     = (e_sml_raw == '0) ? IN_EXP_W'(1) : e_sml_raw;
        sig_big   = {|e_big_raw, f_big};
        sig_sml   = {|e_sml_raw, f_sml};
        shamt     = e_big - e_sml;
        big_field = {sig_big, {PAD{1'b0}}};
        sml_wide  = {sig_sml, {(2*FW-SIG_W){1'b0}}};
        sml_shift = sml_wide >> shamt;
        if (32'(shamt) >= FW) begin
            aligned = {{(FW-1){1'b0}}, |sig_sml};
        end else begin
            aligned = {sml_shift[2*FW-1:FW+1], sml_shift[FW] | (|sml_shift[FW-1:0])};
        end
    end

    logic                s1_valid, s1_sign, s1_zsign, s1_sub, s1_nan, s1_inf, s1_inf_sign;
    logic [IN_EXP_W-1:0] s1_exp;
    logic [FW-1:0]       s1_big, s1_sml;

    // Stage 1 register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid    <= 1'b0;
            s1_sign     <= 1'b0;
            s1_zsign    <= 1'b0;
            s1_sub      <= 1'b0;
            s1_nan      <= 1'b0;
            s1_inf      <= 1'b0;
            s1_inf_sign <= 1'b0;
            s1_exp      <= '0;
            s1_big      <= '0;
            s1_sml      <= '0;
        end else if (adv) begin
            s1_valid    <= in_valid;
            s1_sign     <= s_big;
            s1_zsign    <= sa && sb;
            s1_sub      <= sa ^ sb;
            s1_nan      <= nan_a || nan_b || inf_clash;
            s1_inf      <= inf_a || inf_b;
            s1_inf_sign <= inf_a ? sa : sb;
            s1_exp      <= e_big;
            s1_big      <= big_field;
            s1_sml      <= aligned;
        end
    end

    // ---------------- Stage 2: add/subtract, normalise ----------------
    logic [FW:0]          sum;
    logic [LZW-1:0]       lzc;
    logic [FW-1:0]        norm;
    logic [OUT_EXP_W-1:0] exp_n;

    // Magnitude add or subtract, then normalise so the leading one lands on the hidden-bit slot
    always_comb begin
        sum = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_sml}) : ({1'b0, s1_big} + {1'b0, s1_sml});
        lzc = LZW'(FW);
        for (int i = 0; i < int'(FW); i++) begin
            if (sum[i]) lzc = LZW'(int'(FW) - 1 - i);
        end
        if (sum[FW]) begin
            norm  = {sum[FW:2], sum[1] | sum[0]};
            exp_n = OUT_EXP_W'(s1_exp) + OUT_EXP_W'(BIAS_D) + OUT_EXP_W'(1);
        end else begin
            norm  = sum[FW-1:0] << lzc;
            exp_n = OUT_EXP_W'(s1_exp) + OUT_EXP_W'(BIAS_D) - OUT_EXP_W'(lzc);
        end
    end

    logic                 s2_valid, s2_sign, s2_zsign, s2_zero, s2_nan, s2_inf, s2_inf_sign;
    logic [OUT_EXP_W-1:0] s2_exp;
    logic [FW-1:0]        s2_norm;

    // Stage 2 register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid    <= 1'b0;
            s2_sign     <= 1'b0;
            s2_zsign    <= 1'b0;
            s2_zero     <= 1'b0;
            s2_nan      <= 1'b0;
            s2_inf      <= 1'b0;
            s2_inf_sign <= 1'b0;
            s2_exp      <= '0;
            s2_norm     <= '0;
        end else if (adv) begin
            s2_valid    <= s1_valid;
            s2_sign     <= s1_sign;
            s2_zsign    <= s1_zsign;
            s2_zero     <= (sum == '0);
            s2_nan      <= s1_nan;
            s2_inf      <= s1_inf;
            s2_inf_sign <= s1_inf_sign;
            s2_exp      <= exp_n;
            s2_norm     <= norm;
        end
    end

    // ---------------- Stage 3: round, pack, specials ----------------
    logic                 rnd_l, rnd_g, rnd_r, rnd_s, rnd_inc, man_ovf;
    logic [OUT_MAN_W-1:0] frac_r;
    logic [OUT_EXP_W-1:0] exp_r;
    logic [OUT_W-1:0]     res;

    // Round to nearest-even; specials and exact zero override the rounded value
    always_comb begin
        rnd_l   = s2_norm[3];
        rnd_g   = s2_norm[2];
        rnd_r   = s2_norm[1];
        rnd_s   = s2_norm[0];
        rnd_inc = rnd_g && (rnd_l || rnd_r || rnd_s);
        man_ovf = rnd_inc && (&s2_norm[FW-1:3]);
        frac_r  = s2_norm[FW-2:3] + OUT_MAN_W'(rnd_inc);
        exp_r   = s2_exp + OUT_EXP_W'(man_ovf);
        res     = {s2_sign, exp_r, frac_r};
        if (s2_nan) begin
            res = {1'b0, {OUT_EXP_W{1'b1}}, 1'b1, {(OUT_MAN_W-1){1'b0}}};
        end else if (s2_inf) begin
            res = {s2_inf_sign, {OUT_EXP_W{1'b1}}, {OUT_MAN_W{1'b0}}};
        end else if (s2_zero) begin
            res = {s2_zsign, {(OUT_W-1){1'b0}}};
        end
    end

    // Output register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            out_data  <= res;
        end
    end

`ifdef FP_ADD_FLAGS_EN
    logic snan_a, snan_b, s1_invalid, s2_invalid;
    logic [2:0] flags_n;
    assign snan_a = nan_a && !fa[IN_MAN_W-1];
    assign snan_b = nan_b && !fb[IN_MAN_W-1];

    // Invalid flag travels alongside the data through stages 1 and 2
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_invalid <= 1'b0;
            s2_invalid <= 1'b0;
        end else if (adv) begin
            s1_invalid <= inf_clash || snan_a || snan_b;
            s2_invalid <= s1_invalid;
        end
    end

    // Inexact and zero only describe the finite datapath result
    always_comb begin
        flags_n = {s2_invalid,
                   !s2_nan && !s2_inf && !s2_zero && (rnd_g || rnd_r || rnd_s),
                   !s2_nan && !s2_inf && s2_zero};
    end

    // Flag output register, same timing as out_data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_flags <= 3'b000;
        end else if (adv) begin
            out_flags <= flags_n;
        end
    end
`endif

endmodule

// File: tb/tb_fp_widen_adder_pipe.sv
// Scoreboard bench for fp_widen_adder_pipe (half in, single out): directed vectors with
// hand-computed results, backpressure, and asynchronous reset with items in flight.
module tb_fp_widen_adder_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
`ifdef FP_ADD_FLAGS_EN
    logic [2:0]  out_flags;
`endif

    fp_widen_adder_pipe dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef FP_ADD_FLAGS_EN
        ,
        .out_flags (out_flags)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  flags;
        bit          lat;
        int          cyc;
    } item_t;

    item_t exp_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;
    int    cyc    = 0;
    bit    saw_in_ready_low = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    // Present one operand pair; the expectation is queued at the cycle it is accepted
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [31:0] d, input logic [2:0] f, input bit lat);
        item_t it;
        bit    done;
        done     = 1'b0;
        in_a     = a;
        in_b     = b;
        in_sub   = s;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                it.data  = d;
                it.flags = f;
                it.lat   = lat;
                it.cyc   = cyc;
                exp_q.push_back(it);
                done = 1'b1;
            end
        end
        if (!done) check("accept_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (5) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every transfer and checks held data while stalled
    initial begin
        item_t       it;
        logic [31:0] held = '0;
        bit          holding = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                holding = 1'b0;
            end else begin
                if (!in_ready) saw_in_ready_low = 1'b1;
                if (holding) begin
                    check("hold_valid", {31'b0, out_valid}, 32'd1);
                    check("hold_data", out_data, held);
                end
                holding = 1'b0;
                if (out_valid) begin
                    if (!out_ready) begin
                        holding = 1'b1;
                        held    = out_data;
                    end else if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_output: got %h want none", out_data);
                    end else begin
                        it = exp_q.pop_front();
                        check("data", out_data, it.data);
`ifdef FP_ADD_FLAGS_EN
                        check("flags", {29'b0, out_flags}, {29'b0, it.flags});
`endif
                        if (it.lat) check("latency", 32'(cyc - it.cyc), 32'd3);
                    end
                end
            end
        end
    end

    initial begin
        rstn = 1'b1;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_out_data", out_data, 32'h0);
        rstn = 1'b1;
        #1;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Basic sums, signed zeros, specials, subnormals, rounding
        send(16'h3C00, 16'h3C00, 1'b0, 32'h40000000, 3'b000, 1'b1);
        send(16'h3C00, 16'h3C00, 1'b1, 32'h00000000, 3'b001, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 32'h80000000, 3'b001, 1'b0);
        send(16'h7C00, 16'hFC00, 1'b0, 32'h7FC00000, 3'b100, 1'b0);
        send(16'h7E00, 16'h3C00, 1'b0, 32'h7FC00000, 3'b000, 1'b0);
        send(16'hFC00, 16'h3C00, 1'b0, 32'hFF800000, 3'b000, 1'b0);
        send(16'h7C00, 16'h7C00, 1'b1, 32'h7FC00000, 3'b100, 1'b0);
        send(16'h0001, 16'h0001, 1'b0, 32'h34000000, 3'b000, 1'b0);
        send(16'h7BFF, 16'h0001, 1'b0, 32'h477FE000, 3'b010, 1'b0);
        send(16'h7BFF, 16'h7BFF, 1'b0, 32'h47FFE000, 3'b000, 1'b0);
        send(16'h3C00, 16'h0001, 1'b0, 32'h3F800000, 3'b010, 1'b0);
        send(16'h3C00, 16'h0003, 1'b0, 32'h3F800002, 3'b010, 1'b0);
        send(16'h3C00, 16'h0001, 1'b1, 32'h3F7FFFFF, 3'b000, 1'b0);
        send(16'h4100, 16'hC000, 1'b0, 32'h3F000000, 3'b000, 1'b0);
        send(16'h3800, 16'h3C00, 1'b1, 32'hBF000000, 3'b000, 1'b0);
        send(16'hBC00, 16'h3C00, 1'b1, 32'hC0000000, 3'b000, 1'b0);
        drain();

        // Backpressure: five back-to-back ops while the sink stalls for six cycles
        saw_in_ready_low = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                send(16'h3C00, 16'h3C00, 1'b0, 32'h40000000, 3'b000, 1'b0);
                send(16'h3C00, 16'h3800, 1'b0, 32'h3FC00000, 3'b000, 1'b0);
                send(16'h4000, 16'h4000, 1'b0, 32'h40800000, 3'b000, 1'b0);
                send(16'h3800, 16'h3C00, 1'b1, 32'hBF000000, 3'b000, 1'b0);
                send(16'h4200, 16'h4000, 1'b0, 32'h40A00000, 3'b000, 1'b0);
            end
        join
        drain();
        check("in_ready_fell", {31'b0, saw_in_ready_low}, 32'd1);

        // Asynchronous reset with three items in flight
        send(16'h3C00, 16'h3C00, 1'b0, 32'h40000000, 3'b000, 1'b0);
        send(16'h4000, 16'h4000, 1'b0, 32'h40800000, 3'b000, 1'b0);
        send(16'h4200, 16'h4000, 1'b0, 32'h40A00000, 3'b000, 1'b0);
        check("inflight_valid", {31'b0, out_valid}, 32'd1);
        #1 rstn = 1'b0;
        #1;
        check("async_reset_valid", {31'b0, out_valid}, 32'd0);
        check("async_reset_data", out_data, 32'h0);
        exp_q.delete();
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        send(16'h3C00, 16'h3800, 1'b0, 32'h3FC00000, 3'b000, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
